onfi_cmd_dispatch: RTL

ONFI_CMD_DISPATCH -- requirements
Module: onfi_cmd_dispatch

---
 rtl/onfi_cmd_dispatch_if.sv | 45 ++++
 rtl/onfi_cmd_dispatch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/onfi_cmd_dispatch_if.sv
// onfi_cmd_dispatch_if
//   Bundles the host request channel, the sequencer command channel, the
//   NAND ready/busy line and the host response channel of onfi_cmd_dispatch.
//   slave  : dispatcher side (onfi_cmd_dispatch)
//   master : host + sequencer + NAND side (driver / testbench)
// Signals
//   req_valid/req_ready/req_op[1:0]/req_addr[7:0]/req_data[31:0] : host request
//   seq_start/seq_op[1:0]/seq_addr[7:0]/seq_data[31:0]/seq_done : sequencer
//   onfi_rbn                                                     : NAND R/B#, 0 = busy
//   rsp_valid/rsp_ready/rsp_op[1:0]/rsp_status[1:0]              : host response
//   busy                                                         : dispatcher activity
interface onfi_cmd_dispatch_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [31:0] req_data;

  logic        seq_start;
  logic [1:0]  seq_op;
  logic [7:0]  seq_addr;
  logic [31:0] seq_data;
  logic        seq_done;

  logic        onfi_rbn;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [1:0]  rsp_status;

  logic        busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, seq_done, onfi_rbn, rsp_ready,
    output req_ready, seq_start, seq_op, seq_addr, seq_data, rsp_valid, rsp_op,
           rsp_status, busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, seq_done, onfi_rbn, rsp_ready,
    input  req_ready, seq_start, seq_op, seq_addr, seq_data, rsp_valid, rsp_op,
           rsp_status, busy
  );
endinterface

// File: rtl/onfi_cmd_dispatch.sv
// onfi_cmd_dispatch
//   Queues host feature/reset/status requests in a small FIFO and issues them
//   one at a time to an ONFI command sequencer. After the sequencer reports
//   completion, non-status ops wait tWB and then for R/B# to go ready; each op
//   ends with a response carrying its op code and a completion status
//   (0 OK, 1 R/B timeout, 2 sequencer timeout).
// Parameters
//   FIFO_DEPTH     : request queue entries (power of two, 2..16)
//   TWB_CYCLES     : cycles waited after seq_done before R/B# is sampled (>= 1)
//   TIMEOUT_CYCLES : limit for the wait-for-done and wait-for-ready phases
// Ports
//   onfi_clk : clock, all logic on posedge
//   onfi_rst : synchronous active-high reset
//   bus      : onfi_cmd_dispatch_if.slave (request, sequencer, R/B#, response, busy)
module onfi_cmd_dispatch #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TWB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               onfi_clk,
  input  logic               onfi_rst,
  onfi_cmd_dispatch_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WB_W  = (TWB_CYCLES > 1) ? $clog2(TWB_CYCLES) : 1;
  localparam int unsigned ENT_W = 2 + 8 + 32;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_WAIT_WB   = 3'd3;
  localparam logic [2:0] S_WAIT_RB   = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [1:0] OP_READ_STATUS = 2'd3;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_RB_TO  = 2'd1;
  localparam logic [1:0] ST_SEQ_TO = 2'd2;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WB_W-1:0]  WB_LOAD  = WB_W'(TWB_CYCLES - 1);

  logic [2:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [WB_W-1:0]  r_wb_cnt;

  logic [1:0]       r_seq_op;
  logic [7:0]       r_seq_addr;
  logic [31:0]      r_seq_data;
  logic [1:0]       r_rsp_op;
  logic [1:0]       r_rsp_status;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_req_ready;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  // Ready depends only on the stored count, so a pop in the same cycle
  // never opens a slot for a push while full. Forced low during reset.
  assign w_req_ready = !onfi_rst && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_pop       = (r_state == S_ISSUE);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge onfi_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_op, bus.req_addr, bus.req_data};
    end
  end

  always_ff @(posedge onfi_clk) begin
    if (onfi_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge onfi_clk) begin
    if (onfi_rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_wb_cnt     <= '0;
      r_seq_op     <= '0;
      r_seq_addr   <= '0;
      r_seq_data   <= '0;
      r_rsp_op     <= '0;
      r_rsp_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The head entry is latched here so seq_* are already valid while
          // seq_start is high; the entry itself is popped as ISSUE ends.
          if (r_count != '0) begin
            {r_seq_op, r_seq_addr, r_seq_data} <= w_head;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A done arriving on the last allowed cycle still counts as done.
          if (bus.seq_done) begin
            if (r_seq_op == OP_READ_STATUS) begin
              r_rsp_op     <= r_seq_op;
              r_rsp_status <= ST_OK;
              r_state      <= S_RESP;
            end else begin
              r_wb_cnt <= WB_LOAD;
              r_state  <= S_WAIT_WB;
            end
          end else if (r_timer == TMR_LAST) begin
            r_rsp_op     <= r_seq_op;
            r_rsp_status <= ST_SEQ_TO;
            r_state      <= S_RESP;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_WB: begin
          if (r_wb_cnt == '0) begin
            r_timer <= '0;
            r_state <= S_WAIT_RB;
          end else begin
            r_wb_cnt <= r_wb_cnt - 1'b1;
          end
        end
        S_WAIT_RB: begin
          // Ready seen on the timeout cycle wins over the timeout.
          if (bus.onfi_rbn) begin
            r_rsp_op     <= r_seq_op;
            r_rsp_status <= ST_OK;
            r_state      <= S_RESP;
          end else if (r_timer == TMR_LAST) begin
            r_rsp_op     <= r_seq_op;
            r_rsp_status <= ST_RB_TO;
            r_state      <= S_RESP;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.seq_start  = (r_state == S_ISSUE);
  assign bus.seq_op     = r_seq_op;
  assign bus.seq_addr   = r_seq_addr;
  assign bus.seq_data   = r_seq_data;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_op     = r_rsp_op;
  assign bus.rsp_status = r_rsp_status;
  assign bus.busy       = (r_count != '0) || (r_state != S_IDLE);

endmodule
